piso_32bit_tx: RTL and testbench
================================

// Module: piso_32bit_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: the opposite direction of the PIPO word register.
//  - Accepts a WIDTH-bit word through a valid/ready load handshake.
//  - Shifts the word out one bit per accepted shift_en strobe, with a bit counter and a last-bit flag.
//  - Sits between a PIPO-held word and a 1-bit link; the matching SIPO receiver reassembles the word.
// PARAMETERS
//  WIDTH      32  data word width in bits (>=2)
//  MSB_FIRST  0   0: D[0] is transmitted first; 1: D[WIDTH-1] is transmitted first
// PORTS
//  clk         in   1      single clock, all state updates on the rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  D           in   WIDTH  parallel word to transmit
//  load_valid  in   1      D is valid; load is accepted when load_valid && load_ready
//  load_ready  out  1      high only in IDLE
//  shift_en    in   1      sink has consumed the current sout bit; advance to the next bit
//  sout        out  1      serial data bit; 0 whenever sout_valid=0
//  sout_valid  out  1      sout carries a frame bit
//  last        out  1      high while the final bit of the frame is on sout
//  busy        out  1      equals ~load_ready
// BEHAVIOUR
//  State machine:
//  - States: IDLE, SHIFT (and PAR when PARITY_EN is defined).
//  - Reset (async, on rst_n=0): state=IDLE, shift reg=0, count=0.
//    Outputs during reset: sout=0, sout_valid=0, last=0, load_ready=1, busy=0.
//  - IDLE: load_ready=1. On an accepted load at edge k, D is captured, count=0, state=SHIFT.
//    Bit 0 of the frame appears on sout in the cycle after edge k (latency 1).
//    shift_en is ignored in IDLE.
//  - SHIFT: sout_valid=1. sout = sreg[0] (MSB_FIRST=0) or sreg[WIDTH-1] (MSB_FIRST=1); sout is combinational from sreg.
//    The current bit holds for any number of cycles with shift_en=0.
//    Each edge with shift_en=1: shift by one toward the output end, count+1.
//  - last=1 while count==WIDTH-1, the final data bit (without PARITY_EN).
//    shift_en at that count moves the state to IDLE; load_ready rises in the next cycle.
//    Frames have no back-to-back overlap: minimum one IDLE cycle between frames.
//  - load_valid during SHIFT/PAR is ignored and D is not sampled. The source holds load_valid until ready.
//  - Count width is $clog2(WIDTH+1). Count never wraps: it is cleared on each load.
//  - Vacated shift-register positions fill with 0.
//  - Reset asserted mid-frame aborts the frame immediately; no partial word is retained.
//  - All outputs are functions of registered state only; there is no combinational path from any input to any output.
// CONFIGURATION
//  Macro PARITY_EN:
//  - Defined: an even-parity bit (^D of the loaded word, captured at load) is sent after the WIDTH data bits.
//    - shift_en at count==WIDTH-1 enters PAR instead of IDLE, and last=0 on that data bit.
//    - PAR: sout=parity, sout_valid=1, last=1. shift_en returns to IDLE.
//    - Frame length is WIDTH+1 bits.
//  - Undefined: PAR state and the parity register do not exist. Frame length is WIDTH bits.
// TESTING
//  1. Assert rst_n=0 mid-cycle with no clock edge -> sout=0, sout_valid=0, last=0, load_ready=1 immediately.
//  2. Load D=32'hA5A5_0F0F, MSB_FIRST=0, shift_en=1 always -> sout=1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1;
//     last only on bit 31; load_ready=1 the following cycle.
//  3. MSB_FIRST=1, D=32'h8000_0001, shift_en toggling 1,0 -> sout=1 held 2 cycles, then 30 zeros (2 cycles each), then 1 with last=1.
//  4. During SHIFT at count=5, drive load_valid=1 with D=32'hFFFF_FFFF -> ignored, original word continues, load_ready stays 0.
//  5. Load 32'h0000_FFFF, assert rst_n=0 after 10 shifts -> outputs return to reset values at once;
//     the next load of 32'h1 transmits 1 then 31 zeros.
//  6. PARITY_EN defined, D=32'h0000_0007 -> 32 data bits with last=0, then a 33rd bit sout=1 with last=1, then IDLE.

Source files
------------

// File: rtl/piso_32bit_tx.sv
// Parallel-in/serial-out transmitter with a valid/ready load handshake and a strobed shift.
// Optional macro PARITY_EN appends an even-parity bit after the data bits.
`timescale 1ns/1ps
module piso_32bit_tx #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;
    logic             at_end;
    logic             out_bit;
`ifdef PARITY_EN
    logic             parity;
`endif

    assign at_end  = (count == CW'(WIDTH - 1));
    assign out_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = out_bit;
`ifdef PARITY_EN
                if (shift_en && at_end) begin
                    state_nxt = PAR;
                end
`else
                last = at_end;
                if (shift_en && at_end) begin
                    state_nxt = IDLE;
                end
`endif
            end
`ifdef PARITY_EN
            PAR: begin
                sout_valid = 1'b1;
                sout       = parity;
                last       = 1'b1;
                if (shift_en) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = ~load_ready;

    // Loads are only taken in IDLE, so load_valid during a frame never disturbs sreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            count <= '0;
`ifdef PARITY_EN
            parity <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (load_valid) begin
                sreg  <= D;
                count <= '0;
`ifdef PARITY_EN
                parity <= ^D;
`endif
            end
        end else if (state == SHIFT && shift_en) begin
            sreg  <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_32bit_tx.sv
// Scoreboard bench for piso_32bit_tx: one LSB-first and one MSB-first instance share stimulus.
`timescale 1ns/1ps
module tb_piso_32bit_tx;

    typedef struct {
        logic b;
        logic l;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] D;
    logic        load_valid;
    logic        shift_en;
    logic        load_ready0, sout0, sout_valid0, last0, busy0;
    logic        load_ready1, sout1, sout_valid1, last1, busy1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests;
    int   n_fail;

    piso_32bit_tx #(.WIDTH(32), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .D(D), .load_valid(load_valid), .load_ready(load_ready0),
        .shift_en(shift_en), .sout(sout0), .sout_valid(sout_valid0), .last(last0), .busy(busy0)
    );

    piso_32bit_tx #(.WIDTH(32), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .D(D), .load_valid(load_valid), .load_ready(load_ready1),
        .shift_en(shift_en), .sout(sout1), .sout_valid(sout_valid1), .last(last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sout0"}, {31'd0, sout0}, 32'd0);
        chk({tag, "_valid0"}, {31'd0, sout_valid0}, 32'd0);
        chk({tag, "_last0"}, {31'd0, last0}, 32'd0);
        chk({tag, "_ready0"}, {31'd0, load_ready0}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_sout1"}, {31'd0, sout1}, 32'd0);
        chk({tag, "_valid1"}, {31'd0, sout_valid1}, 32'd0);
        chk({tag, "_ready1"}, {31'd0, load_ready1}, 32'd1);
    endtask

    // toggle: shift_en alternates 0,1; hijack: load attempt at count 5..7; abort_at: reset after N shifts
    task automatic run_frame(input logic [31:0] w, input bit toggle, input bit hijack, input int abort_at);
        int  pops;
        bit  ph;
        bit  done;
        logic p;
        @(negedge clk);
        chk("pre_load_ready", {31'd0, load_ready0}, 32'd1);
        q0.delete();
        q1.delete();
        p = ^w;
        for (int i = 0; i < 32; i++) begin
`ifdef PARITY_EN
            q0.push_back('{b: w[i], l: 1'b0});
            q1.push_back('{b: w[31-i], l: 1'b0});
`else
            q0.push_back('{b: w[i], l: (i == 31)});
            q1.push_back('{b: w[31-i], l: (i == 31)});
`endif
        end
`ifdef PARITY_EN
        q0.push_back('{b: p, l: 1'b1});
        q1.push_back('{b: p, l: 1'b1});
`endif
        D          = w;
        load_valid = 1'b1;
        shift_en   = toggle ? 1'b0 : 1'b1;
        pops = 0;
        ph   = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (hijack && pops >= 5 && pops < 8) begin
                load_valid = 1'b1;
                D          = 32'hFFFF_FFFF;
            end
            if (abort_at > 0 && pops == abort_at) begin
                rst_n    = 1'b0;
                shift_en = 1'b0;
                #1;
                chk_reset_outputs("abort");
                q0.delete();
                q1.delete();
                done = 1'b1;
                @(negedge clk);
                rst_n = 1'b1;
            end else if (q0.size() == 0) begin
                shift_en = 1'b0;
                chk("end_ready", {31'd0, load_ready0}, 32'd1);
                chk("end_valid", {31'd0, sout_valid0}, 32'd0);
                chk("end_sout", {31'd0, sout0}, 32'd0);
                chk("end_busy", {31'd0, busy0}, 32'd0);
                done = 1'b1;
            end else begin
                chk("valid0", {31'd0, sout_valid0}, 32'd1);
                chk("ready0", {31'd0, load_ready0}, 32'd0);
                chk("busy0", {31'd0, busy0}, 32'd1);
                chk("sout0", {31'd0, sout0}, {31'd0, q0[0].b});
                chk("last0", {31'd0, last0}, {31'd0, q0[0].l});
                chk("sout1", {31'd0, sout1}, {31'd0, q1[0].b});
                chk("last1", {31'd0, last1}, {31'd0, q1[0].l});
                shift_en = toggle ? ph : 1'b1;
                ph       = ~ph;
                if (shift_en) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                    pops++;
                end
            end
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
        end
        load_valid = 1'b0;
        shift_en   = 1'b0;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        D          = '0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        #13;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(32'hA5A5_0F0F, 1'b0, 1'b0, 0);
        run_frame(32'h8000_0001, 1'b1, 1'b0, 0);
        run_frame(32'h1234_5678, 1'b0, 1'b1, 0);
        run_frame(32'h0000_FFFF, 1'b0, 1'b0, 10);
        run_frame(32'h0000_0001, 1'b0, 1'b0, 0);
        run_frame(32'h0000_0007, 1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            run_frame($urandom, k[0], 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
